// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver (LSB first, idle-high line).
// Receive-side partner of the MMIO UART transmitter. The serial input is
// synchronised, the start bit is qualified at mid-bit, data bits and the stop
// bit are sampled at mid-bit, and each good byte is presented with a
// one-cycle strobe for the MMIO register block.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         serial input, asynchronous to clk, idle high
//   data       last correctly framed byte
//   valid      one-cycle pulse: data updated this cycle
//   frame_err  one-cycle pulse: stop bit sampled low
//   busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Two-flop synchroniser. Both flops reset to the idle (high) level so a
  // reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM. The counter restarts on every state change and every bit
  // sample, so each sample lands a whole bit period after the previous one,
  // starting from the mid-point of the start bit. busy is kept registered
  // and is updated on exactly the transitions into and out of IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            // Shift right from the top so the first (LSB) bit ends in shreg[0].
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              // Data is left untouched; wait for the line to recover so a
              // held-low break reports only one error.
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx with CLKS_PER_BIT = 16.
// Frames are generated at a chosen sender bit period; a reference model
// works out, from the mid-bit sampling rule, which sender bit the receiver
// sees at each sample instant and hence which byte (or framing error) must
// come out. A monitor collects every valid / frame_err pulse.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CLKS = 16;
  localparam int HALF = CLKS / 2;
  // rx is driven just after edge N; edge N+1 is the first to see it (the
  // start edge) and valid appears 2 + HALF + 9*CLKS = 154 edges later.
  localparam int LATENCY = 1 + 2 + HALF + 9 * CLKS;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both_cnt = 0;
  int busy_cnt = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  int err_data = 0;
  int exp_ecnt = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: samples outputs just after each rising edge and records pulses.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (valid) begin
      vcnt = vcnt + 1;
      got_q.push_back(data);
      last_valid_cyc = cyc;
    end
    if (frame_err) begin
      ecnt = ecnt + 1;
      err_data = int'(data);
    end
    if (valid && frame_err) both_cnt = both_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total = total + 1;
    if (observed !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: the receiver looks at the line at HALF + k*CLKS edges
  // past the start edge (k = 1..8 data, 9 stop); the sender bit visible
  // there is simply that offset divided by the sender's bit period.
  function automatic void modelFrame(input logic [7:0] b, input int p, input bit stop,
                                     output logic [7:0] rb, output bit rstop);
    logic v;
    int   idx;
    rb    = 8'h00;
    rstop = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      idx = (HALF + k * CLKS) / p;
      if (idx == 0)      v = 1'b0;
      else if (idx <= 8) v = b[idx-1];
      else if (idx == 9) v = stop;
      else               v = 1'b1;
      if (k <= 8) rb[k-1] = v;
      else        rstop = v;
    end
  endfunction

  // Sends one frame at bit period p and leaves rx at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] b, input int p, input bit stop);
    logic [7:0] rb;
    bit         rstop;
    modelFrame(b, p, stop, rb, rstop);
    if (rstop) exp_q.push_back(rb);
    else       exp_ecnt = exp_ecnt + 1;
    @(negedge clk);
    start_cyc = cyc;
    rx = 1'b0;
    waitCycles(p - 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = b[i];
      waitCycles(p - 1);
    end
    @(negedge clk);
    rx = stop;
    waitCycles(p - 1);
  endtask

  // Compares every collected byte against the model and drains both queues.
  task automatic compareFrames(input string tag);
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      checkOutput({tag, "_data"}, int'(got_q.pop_front()), int'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    checkOutput({tag, "_errs"}, ecnt, exp_ecnt);
    checkOutput({tag, "_overlap"}, both_cnt, 0);
  endtask

  initial begin
    int gap;
    int p;
    rst_n = 1'b0;
    rx    = 1'b1;

    // Reset state.
    waitCycles(5);
    checkOutput("rst_data", int'(data), 0);
    checkOutput("rst_valid", int'(valid), 0);
    checkOutput("rst_ferr", int'(frame_err), 0);
    checkOutput("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    waitCycles(10);

    // Reset during a frame: start bit plus three data bits of 0xF0, then abort.
    rx = 1'b0;
    waitCycles(CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b0;
      waitCycles(CLKS);
    end
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(20);
    checkOutput("abort_pulses", vcnt + ecnt, 0);
    applyStimulus(8'h81, CLKS, 1'b1);
    rx = 1'b1;
    waitCycles(20);
    compareFrames("after_abort");

    // Two frames with a 2-bit gap, including the start-to-valid latency.
    applyStimulus(8'h55, CLKS, 1'b1);
    checkOutput("lat_55", last_valid_cyc - start_cyc, LATENCY);
    rx = 1'b1;
    waitCycles(2 * CLKS);
    applyStimulus(8'hA3, CLKS, 1'b1);
    checkOutput("lat_a3", last_valid_cyc - start_cyc, LATENCY);
    rx = 1'b1;
    waitCycles(2 * CLKS);
    compareFrames("gap2");

    // Short glitch: busy only for the half-bit qualification window.
    busy_cnt = 0;
    rx = 1'b0;
    waitCycles(4);
    rx = 1'b1;
    waitCycles(30);
    checkOutput("glitch_busy", busy_cnt, HALF);
    checkOutput("glitch_data", int'(data), 'hA3);
    compareFrames("glitch");

    // Bad stop bit followed by a long break.
    applyStimulus(8'h3C, CLKS, 1'b0);
    checkOutput("ferr_count", ecnt, 1);
    checkOutput("ferr_data", err_data, 'hA3);
    waitCycles(100);
    checkOutput("break_errs", ecnt, 1);
    checkOutput("break_busy", int'(busy), 1);
    rx = 1'b1;
    waitCycles(10);
    checkOutput("break_recover", int'(busy), 0);
    applyStimulus(8'h0F, CLKS, 1'b1);
    rx = 1'b1;
    waitCycles(20);
    compareFrames("break");

    // Back-to-back frames with no idle time.
    applyStimulus(8'h00, CLKS, 1'b1);
    applyStimulus(8'hFF, CLKS, 1'b1);
    applyStimulus(8'h5A, CLKS, 1'b1);
    rx = 1'b1;
    waitCycles(20);
    compareFrames("b2b");

    // Sender clock mismatch.
    applyStimulus(8'hC6, 15, 1'b1);
    rx = 1'b1;
    waitCycles(40);
    applyStimulus(8'hC6, 17, 1'b1);
    rx = 1'b1;
    waitCycles(40);
    compareFrames("skew");

    // Random bytes, periods and gaps.
    for (int n = 0; n < 12; n++) begin
      p   = ($urandom_range(0, 1) == 0) ? 15 : 16;
      gap = (p == 16) ? int'($urandom_range(0, 40)) : int'($urandom_range(8, 40));
      applyStimulus(8'($urandom), p, 1'b1);
      rx = 1'b1;
      if (gap > 0) waitCycles(gap);
    end
    rx = 1'b1;
    waitCycles(40);
    compareFrames("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
